load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a 32-word combinational-read data memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] mem_read_addr,
    input  logic [31:0]       mem_read_data,
    output logic [ADDR_W-3:0] mem_write_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_we
);

    localparam int unsigned WORD_AW = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;

    logic              misalign_c;
    logic              err_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       load_c;
    logic [31:0]       merge_c;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = ((r_size == 2'b01) && r_addr[0]) ||
                        ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign err_c     = (r_size == 2'b11) || misalign_c;
    assign req_ready = (state == IDLE) && !rst;
    // Write strobe is gated by rst so an aborted ACCESS never commits.
    assign mem_we         = (state == ACCESS) && !rst && r_we && !err_c;
    assign mem_write_data = merge_c;

    // Lane selection and extension for loads.
    always_comb begin
        byte_c = mem_read_data[7:0];
        half_c = mem_read_data[15:0];
        load_c = mem_read_data;
        case (r_addr[1:0])
            2'd0:    byte_c = mem_read_data[7:0];
            2'd1:    byte_c = mem_read_data[15:8];
            2'd2:    byte_c = mem_read_data[23:16];
            default: byte_c = mem_read_data[31:24];
        endcase
        half_c = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (r_size)
            2'b00:   load_c = {{24{~r_unsigned & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{~r_unsigned & half_c[15]}}, half_c};
            default: load_c = mem_read_data;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes store data.
    always_comb begin
        merge_c = mem_read_data;
        case (r_size)
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    merge_c[7:0]   = r_wdata[7:0];
                    2'd1:    merge_c[15:8]  = r_wdata[7:0];
                    2'd2:    merge_c[23:16] = r_wdata[7:0];
                    default: merge_c[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) merge_c[31:16] = r_wdata[15:0];
                else           merge_c[15:0]  = r_wdata[15:0];
            end
            2'b10:   merge_c = r_wdata;
            default: merge_c = mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_wdata        <= 32'd0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state          <= ACCESS;
                        r_we           <= req_we;
                        r_addr         <= req_addr;
                        r_size         <= req_size;
                        r_unsigned     <= req_unsigned;
                        r_wdata        <= req_wdata;
                        mem_read_addr  <= WORD_AW'(req_addr[ADDR_W-1:2]);
                        mem_write_addr <= WORD_AW'(req_addr[ADDR_W-1:2]);
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_c;
                    rsp_rdata <= (err_c || r_we) ? 32'd0 : load_c;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 32-word data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_read_addr;
    logic [31:0] mem_read_data;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_we;

    logic [31:0] mem [32];
    logic        mem_init;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    load_store_unit #(.ADDR_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_read_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_write_addr] <= mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [6:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_we, input logic [31:0] exp_wdata);
        exp_t e;
        int n;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, "_mem_we"}, 32'(mem_we), 32'(exp_we));
        chk({name, "_rd_addr"}, 32'(mem_read_addr), 32'(addr[6:2]));
        if (exp_we) begin
            chk({name, "_wr_addr"}, 32'(mem_write_addr), 32'(addr[6:2]));
            chk({name, "_wr_data"}, mem_write_data, exp_wdata);
        end
        @(negedge clk);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_busy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w2_after_mis;
        logic [31:0] mis_half_rdata;
        logic        mis_err;
`ifdef LSU_MISALIGN_TRAP_EN
        w2_after_mis   = 32'h8001BEEF;
        mis_half_rdata = 32'd0;
        mis_err        = 1'b1;
`else
        w2_after_mis   = 32'h11223344;
        mis_half_rdata = 32'h00003344;
        mis_err        = 1'b0;
`endif
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0; mem_init = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rd_addr", 32'(mem_read_addr), 32'd0);
        chk("rst_wr_addr", 32'(mem_write_addr), 32'd0);
        chk("rst_ready_low", 32'(req_ready), 32'd1);

        do_req("sw_dead", 1, 7'h08, 2'b10, 0, 32'hDEADBEEF, 32'd0, 0, 1, 32'hDEADBEEF);
        chk("mem2_dead", mem[2], 32'hDEADBEEF);
        do_req("sw_5", 1, 7'h08, 2'b10, 0, 32'h00000005, 32'd0, 0, 1, 32'h00000005);
        do_req("sb_ab", 1, 7'h09, 2'b00, 0, 32'h123456AB, 32'd0, 0, 1, 32'h0000AB05);
        chk("mem2_ab05", mem[2], 32'h0000AB05);
        do_req("lb_s", 0, 7'h09, 2'b00, 0, 32'd0, 32'hFFFFFFAB, 0, 0, 32'd0);
        do_req("lb_u", 0, 7'h09, 2'b00, 1, 32'd0, 32'h000000AB, 0, 0, 32'd0);
        do_req("lh_u_lo", 0, 7'h08, 2'b01, 1, 32'd0, 32'h0000AB05, 0, 0, 32'd0);
        do_req("sw_8001", 1, 7'h08, 2'b10, 0, 32'h80010005, 32'd0, 0, 1, 32'h80010005);
        do_req("lh_s_hi", 0, 7'h0A, 2'b01, 0, 32'd0, 32'hFFFF8001, 0, 0, 32'd0);
        do_req("lb_s_b3", 0, 7'h0B, 2'b00, 0, 32'd0, 32'hFFFFFF80, 0, 0, 32'd0);
        do_req("sh_lo", 1, 7'h08, 2'b01, 0, 32'hCAFEBEEF, 32'd0, 0, 1, 32'h8001BEEF);
        do_req("sw_mis", 1, 7'h0A, 2'b10, 0, 32'h11223344, 32'd0, mis_err, !mis_err, 32'h11223344);
        chk("mem2_mis", mem[2], w2_after_mis);
        do_req("ld_ill", 0, 7'h04, 2'b11, 0, 32'd0, 32'd0, 1, 0, 32'd0);
        do_req("st_ill", 1, 7'h04, 2'b11, 0, 32'hFFFFFFFF, 32'd0, 1, 0, 32'd0);
        chk("mem1_ill", mem[1], 32'd0);

        // Abort a byte store by pulsing rst during its ACCESS cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h10; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h00000077;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("mem4_abort", mem[4], 32'd0);

        do_req("lw_post", 0, 7'h08, 2'b10, 0, 32'd0, w2_after_mis, 0, 0, 32'd0);
        do_req("lh_mis", 0, 7'h09, 2'b01, 0, 32'd0, mis_half_rdata, mis_err, 0, 32'd0);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
